zprize_mul_issue_ctrl: RTL and testbench

//   Initiator side of the fixed-latency field multiplier (no backpressure, metadata pipelined alongside product).
//   - Accepts operand pairs on a valid/ready slave port and issues them with a {tag,valid} metadata word.
//   - Collects mul_out0/mul_m_o into a result FIFO, exposing a valid/ready master port to the bucket/accumulate logic.
//   - Credit scheme guarantees the FIFO never overflows even though the multiplier cannot stall.

---
 rtl/zprize_mul_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_zprize_mul_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zprize_mul_issue_ctrl.sv
// Issue/collect controller for a fixed-latency field multiplier that cannot stall.
// The credit counter reserves a FIFO slot for every issued operation, so results never overflow.
//
// state | meaning
// DRAIN | flushing stale multiplier contents after reset; no issue, mul_m_o ignored
// RUN   | normal issue and collect
module zprize_mul_issue_ctrl #(
  parameter int W0         = 384,
  parameter int W1         = 384,
  parameter int M          = 32,
  parameter int LAT        = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [W0-1:0]                     s_a,
  input  logic [W1-1:0]                     s_b,
  input  logic [M-2:0]                      s_tag,
  output logic [W0-1:0]                     mul_in0,
  output logic [W1-1:0]                     mul_in1,
  output logic [M-1:0]                      mul_m_i,
  input  logic [M-1:0]                      mul_m_o,
  input  logic [W0+W1-1:0]                  mul_out0,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [W0+W1-1:0]                  m_p,
  output logic [M-2:0]                      m_tag,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   inflight,
  output logic                              err_orphan
);

  localparam int PW = W0 + W1;
  localparam int EW = PW + M - 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = $clog2(LAT + 2);

  generate
    if (FIFO_DEPTH < 2) begin : g_depth_check
      $error("zprize_mul_issue_ctrl: FIFO_DEPTH must be >= 2");
    end
  endgenerate

  typedef enum logic {DRAIN, RUN} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;

  logic [CW-1:0] credits_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] count_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] mem [FIFO_DEPTH];

  logic run, fire, pop, mo_valid, push, orphan;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DRAIN;
      cnt_q   <= DW'(LAT + 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The last drain cycle is the one where the down-counter reaches its terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DRAIN: begin
        if (cnt_q <= DW'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      RUN: ;
      default: state_d = DRAIN;
    endcase
  end

  assign run      = (state_q == RUN);
  assign s_ready  = run && (credits_q != '0);
  assign fire     = s_valid && s_ready;
  assign m_valid  = (count_q != '0);
  assign pop      = m_valid && m_ready;
  assign mo_valid = run && mul_m_o[0];
  assign push     = mo_valid && (inflight_q != '0);
  assign orphan   = mo_valid && (inflight_q == '0);
  assign inflight = inflight_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_m_i <= '0;
    end else if (fire) begin
      mul_m_i <= {s_tag, 1'b1};
    end else begin
      mul_m_i[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      mul_in0 <= s_a;
      mul_in1 <= s_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q  <= CW'(FIFO_DEPTH);
      inflight_q <= '0;
      err_orphan <= 1'b0;
    end else begin
      unique case ({fire, pop})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   credits_q <= credits_q + CW'(1);
        default: ;
      endcase
      unique case ({fire, push})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: ;
      endcase
      if (orphan) err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {mul_m_o[M-1:1], mul_out0};
  end

  assign {m_tag, m_p} = mem[rd_ptr];

endmodule

// File: tb/tb_zprize_mul_issue_ctrl.sv
// Directed bench for zprize_mul_issue_ctrl with a behavioural fixed-latency multiplier
// and a queue scoreboard filled at issue and drained at result pop.
module tb_zprize_mul_issue_ctrl;

  localparam int W0  = 384;
  localparam int W1  = 384;
  localparam int M   = 32;
  localparam int LAT = 5;
  localparam int FD  = 8;
  localparam int PW  = W0 + W1;
  localparam int EW  = PW + M - 1;
  localparam int CW  = $clog2(FD + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W0-1:0] s_a = '0;
  logic [W1-1:0] s_b = '0;
  logic [M-2:0]  s_tag = '0;
  logic [W0-1:0] mul_in0;
  logic [W1-1:0] mul_in1;
  logic [M-1:0]  mul_m_i;
  logic [M-1:0]  mul_m_o;
  logic [PW-1:0] mul_out0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [PW-1:0] m_p;
  logic [M-2:0]  m_tag;
  logic [CW-1:0] inflight;
  logic          err_orphan;
  logic          inj = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_fire = 0;
  int n_pop = 0;
  int first_pop = -1;
  int last_pop = -1;
  logic [EW-1:0] sb_q[$];

  always #5 clk = ~clk;

  zprize_mul_issue_ctrl #(.W0(W0), .W1(W1), .M(M), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_tag(s_tag),
    .mul_in0(mul_in0), .mul_in1(mul_in1), .mul_m_i(mul_m_i),
    .mul_m_o(mul_m_o), .mul_out0(mul_out0),
    .m_valid(m_valid), .m_ready(m_ready), .m_p(m_p), .m_tag(m_tag),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  // Multiplier model: LAT stages, no reset, product formed in the first stage.
  logic [PW-1:0] pipe_p [LAT];
  logic [M-1:0]  pipe_m [LAT];
  always @(posedge clk) begin
    pipe_p[0] <= PW'(mul_in0) * PW'(mul_in1);
    pipe_m[0] <= mul_m_i;
    for (int i = 1; i < LAT; i++) begin
      pipe_p[i] <= pipe_p[i-1];
      pipe_m[i] <= pipe_m[i-1];
    end
  end
  assign mul_out0 = pipe_p[LAT-1];
  assign mul_m_o  = inj ? (pipe_m[LAT-1] | M'(1)) : pipe_m[LAT-1];

  task automatic chk(input string name, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [W0-1:0] rnd384();
    logic [W0-1:0] r;
    for (int i = 0; i < W0 / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Scoreboard bookkeeping for the upcoming edge, then advance one cycle.
  task automatic tick();
    logic [PW-1:0] prod;
    logic [EW-1:0] exp;
    if (s_valid && s_ready) begin
      prod = PW'(s_a) * PW'(s_b);
      sb_q.push_back({s_tag, prod});
      n_fire++;
    end
    if (m_valid && m_ready) begin
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected observed=%0h expected=none", m_p);
      end
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        chk("sb_p", EW'(m_p), EW'(exp[PW-1:0]));
        chk("sb_tag", EW'(m_tag), EW'(exp[EW-1:PW]));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_drain(input string name, input bit inject);
    int n;
    int mv;
    n = 0;
    mv = 0;
    while (!s_ready && n < 20) begin
      if (m_valid) mv++;
      inj = inject && (n == 2);
      tick();
      inj = 1'b0;
      n++;
    end
    chk({name, "_drain_cycles"}, EW'(n), EW'(LAT + 1));
    chk({name, "_drain_mvalid"}, EW'(mv), '0);
  endtask

  initial begin
    // 1: reset values and drain window with a garbage result injected
    rst = 1'b1;
    tick();
    chk("rst_s_ready", EW'(s_ready), '0);
    chk("rst_m_valid", EW'(m_valid), '0);
    chk("rst_inflight", EW'(inflight), '0);
    chk("rst_err", EW'(err_orphan), '0);
    chk("rst_mul_m_i", EW'(mul_m_i), '0);
    tick();
    rst = 1'b0;
    wait_drain("t1", 1'b1);
    chk("t1_m_valid", EW'(m_valid), '0);
    chk("t1_err", EW'(err_orphan), '0);
    chk("t1_s_ready", EW'(s_ready), EW'(1));

    // 2: single op latency
    m_ready = 1'b1;
    s_valid = 1'b1; s_a = W0'(3); s_b = W1'(5); s_tag = (M-1)'('h11);
    tick();
    s_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      chk("t2_inflight", EW'(inflight), EW'((k <= LAT + 1) ? 1 : 0));
      chk("t2_m_valid", EW'(m_valid), EW'((k == LAT + 2) ? 1 : 0));
      if (k == LAT + 2) begin
        chk("t2_m_p", EW'(m_p), EW'(15));
        chk("t2_m_tag", EW'(m_tag), EW'('h11));
      end
      tick();
    end

    // 3: sustained stream
    begin
      int stall;
      stall = 0; n_pop = 0; first_pop = -1; last_pop = -1;
      for (int i = 0; i < 100; i++) begin
        s_valid = 1'b1; s_a = rnd384(); s_b = rnd384(); s_tag = (M-1)'(i + 256);
        if (!s_ready) stall++;
        tick();
      end
      s_valid = 1'b0;
      repeat (12) tick();
      chk("t3_stalls", EW'(stall), '0);
      chk("t3_pops", EW'(n_pop), EW'(100));
      chk("t3_contiguous", EW'(last_pop - first_pop + 1), EW'(100));
      chk("t3_sb_empty", EW'(sb_q.size()), '0);
    end

    // 4: backpressure, credit count
    m_ready = 1'b0; n_fire = 0;
    s_valid = 1'b1; s_a = W0'(7); s_b = W1'(9);
    for (int i = 0; i < 20; i++) begin
      s_tag = (M-1)'(i);
      tick();
    end
    chk("t4_fires", EW'(n_fire), EW'(FD));
    chk("t4_s_ready", EW'(s_ready), '0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    repeat (10) tick();
    chk("t4_fires_after_pop", EW'(n_fire), EW'(FD + 1));
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (15) tick();
    chk("t4_sb_empty", EW'(sb_q.size()), '0);

    // 5: orphan result
    chk("t5_pre_err", EW'(err_orphan), '0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("t5_err", EW'(err_orphan), EW'(1));
    chk("t5_m_valid", EW'(m_valid), '0);
    chk("t5_inflight", EW'(inflight), '0);
    repeat (3) tick();
    chk("t5_err_sticky", EW'(err_orphan), EW'(1));

    // 6: reset with results queued and in flight
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_a = rnd384(); s_b = rnd384(); s_tag = (M-1)'(i + 512);
      tick();
    end
    s_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (inflight != '0 && n < 20) begin tick(); n++; end
      chk("t6_landed", EW'(inflight), '0);
    end
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_a = rnd384(); s_b = rnd384(); s_tag = (M-1)'(i + 600);
      tick();
    end
    s_valid = 1'b0;
    chk("t6_inflight3", EW'(inflight), EW'(3));
    chk("t6_queued4", EW'(m_valid), EW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    chk("t6_rst_m_valid", EW'(m_valid), '0);
    chk("t6_rst_inflight", EW'(inflight), '0);
    chk("t6_rst_err", EW'(err_orphan), '0);
    m_ready = 1'b1;
    wait_drain("t6", 1'b0);
    chk("t6_m_valid", EW'(m_valid), '0);
    chk("t6_err", EW'(err_orphan), '0);
    chk("t6_inflight", EW'(inflight), '0);
    m_ready = 1'b0; n_fire = 0;
    s_valid = 1'b1; s_a = W0'(11); s_b = W1'(13); s_tag = (M-1)'('h77);
    repeat (20) tick();
    chk("t6_credits", EW'(n_fire), EW'(FD));
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (15) tick();
    chk("t6_sb_empty", EW'(sb_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
